// File: rtl/bnn_load_if.sv
// bnn_load_if: load-sequencer bus between the input synchronizer, buffers and compute engine
//   master: driven by bnn_load_ctrl (buffer writes, compute start, status)
//   slave : the surrounding logic (synchronized streams, compute done)
interface bnn_load_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 7
);
  logic              sync_p;
  logic              sync_w;
  logic              sync_en;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [WORD_W-1:0] pix_wdata;
  logic [WORD_W-1:0] wgt_wdata;
  logic              comp_start;
  logic              comp_done;
  logic              busy;
  logic              frame_ok;
  logic              err_short;
  logic              err_long;
  modport master (
    input  sync_p, sync_w, sync_en, comp_done,
    output buf_we, buf_waddr, pix_wdata, wgt_wdata, comp_start, busy, frame_ok, err_short, err_long
  );
  modport slave (
    output sync_p, sync_w, sync_en, comp_done,
    input  buf_we, buf_waddr, pix_wdata, wgt_wdata, comp_start, busy, frame_ok, err_short, err_long
  );
endinterface

// File: rtl/bnn_load_ctrl.sv
// bnn_load_ctrl: frame-load sequencer; deserializes pixel/weight bit streams into buffer words,
// then starts the compute engine and waits for completion.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (master) : sync_p/sync_w/sync_en streams in, buf_we/buf_waddr/pix_wdata/wgt_wdata out,
//                  comp_start out / comp_done in, busy/frame_ok/err_short/err_long status out
module bnn_load_ctrl #(
  parameter int N_BITS = 784,
  parameter int WORD_W = 8,
  parameter int ADDR_W = 7
) (
  input logic        clk,
  input logic        reset_n,
  bnn_load_if.master bus
);
  localparam int CNT_W = $clog2(N_BITS + 1);
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, COMPUTE} state_t;
  state_t            state, state_nx;
  logic              en_q;
  logic              armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  idx;
  logic [WORD_W-1:0] pix_sr, wgt_sr;
  logic [WORD_W-1:0] pix_nx, wgt_nx;
  logic              start, accept, sample, last, word_end, set_short, set_long;
  always_comb begin
    // armed blocks a frame when sync_en is already high coming out of reset
    start     = bus.sync_en && !en_q && armed;
    accept    = state == IDLE && start;
    // the bit sampled in IDLE is always bit 0, whatever bit_cnt was left at
    idx       = state == IDLE ? '0 : bit_cnt;
    sample    = accept || (state == LOAD && bus.sync_en);
    last      = idx == CNT_W'(N_BITS - 1);
    word_end  = (idx % CNT_W'(WORD_W)) == CNT_W'(WORD_W - 1);
    set_short = state == LOAD && !bus.sync_en;
    set_long  = state == FLUSH && bus.sync_en;
    pix_nx    = {pix_sr[WORD_W-2:0], bus.sync_p};
    wgt_nx    = {wgt_sr[WORD_W-2:0], bus.sync_w};
    state_nx  = state == IDLE  ? (accept ? LOAD : IDLE) :
                state == LOAD  ? (!bus.sync_en ? IDLE : last ? FLUSH : LOAD) :
                state == FLUSH ? START :
                state == START ? COMPUTE :
                                 (bus.comp_done ? IDLE : COMPUTE);
    bus.busy       = state != IDLE;
    bus.comp_start = state == START;
    bus.frame_ok   = state == COMPUTE && bus.comp_done;
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  always_ff @(posedge clk)
    if (!reset_n) begin
      en_q          <= 1'b0;
      armed         <= !bus.sync_en;
      bit_cnt       <= '0;
      pix_sr        <= '0;
      wgt_sr        <= '0;
      bus.buf_we    <= 1'b0;
      bus.buf_waddr <= '0;
      bus.pix_wdata <= '0;
      bus.wgt_wdata <= '0;
      bus.err_short <= 1'b0;
      bus.err_long  <= 1'b0;
    end else begin
      en_q          <= bus.sync_en;
      armed         <= armed || !bus.sync_en;
      bus.buf_we    <= sample && word_end;
      if (sample) begin
        bit_cnt <= idx + CNT_W'(1);
        pix_sr  <= pix_nx;
        wgt_sr  <= wgt_nx;
      end
      if (sample && word_end) begin
        bus.buf_waddr <= ADDR_W'(idx / CNT_W'(WORD_W));
        bus.pix_wdata <= pix_nx;
        bus.wgt_wdata <= wgt_nx;
      end
      bus.err_short <= !accept && (bus.err_short || set_short);
      bus.err_long  <= !accept && (bus.err_long || set_long);
    end
endmodule

// File: tb/tb_bnn_load_ctrl.sv
// tb_bnn_load_ctrl: directed self-checking bench for bnn_load_ctrl (N_BITS=16, WORD_W=8)
module tb_bnn_load_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_start = 0;
  int   n_ok = 0;
  logic [6:0] wa[$];
  logic [7:0] wp[$];
  logic [7:0] wg[$];
  bnn_load_if #(.WORD_W(8), .ADDR_W(7)) bus ();
  bnn_load_ctrl #(.N_BITS(16), .WORD_W(8), .ADDR_W(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.buf_we) begin
      wa.push_back(bus.buf_waddr);
      wp.push_back(bus.pix_wdata);
      wg.push_back(bus.wgt_wdata);
    end
    if (bus.comp_start) n_start++;
    if (bus.frame_ok) n_ok++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_log();
    wa.delete();
    wp.delete();
    wg.delete();
  endtask
  task automatic send(input logic [15:0] p, input logic [15:0] w, input int n, input int done_at);
    logic [15:0] sp, sw;
    sp = p;
    sw = w;
    for (int i = 0; i < n; i++) begin
      bus.sync_en   = 1'b1;
      bus.sync_p    = sp[15];
      bus.sync_w    = sw[15];
      bus.comp_done = (i == done_at);
      sp = sp << 1;
      sw = sw << 1;
      step();
    end
    bus.sync_en   = 1'b0;
    bus.sync_p    = 1'b0;
    bus.sync_w    = 1'b0;
    bus.comp_done = 1'b0;
  endtask
  task automatic done_pulse();
    repeat (5) step();
    bus.comp_done = 1'b1;
    step();
    bus.comp_done = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    n_chk++;
    if ({bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start, bus.busy, bus.frame_ok, bus.err_short, bus.err_long} !== '0)
      $display("FAIL reset_outputs got we=%0b addr=%0d pix=%h wgt=%h start=%0b busy=%0b ok=%0b es=%0b el=%0b exp all 0",
               bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start, bus.busy, bus.frame_ok, bus.err_short, bus.err_long);
    else n_pass++;
  endtask
  task automatic test_nominal();
    int s0, o0;
    clear_log();
    s0 = n_start;
    o0 = n_ok;
    bus.sync_en = 1'b1;
    bus.sync_p  = 1'b1;
    bus.sync_w  = 1'b0;
    step();
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL nom_busy_first_bit got %0b exp 1", bus.busy); else n_pass++;
    send(16'h4A78, 16'hB586, 15, -1);
    n_chk++;
    if ({bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start} !== {1'b1, 7'd1, 8'h3C, 8'hC3, 1'b0})
      $display("FAIL nom_last_write got we=%0b addr=%0d pix=%h wgt=%h start=%0b exp 1 1 3c c3 0",
               bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start);
    else n_pass++;
    step();
    n_chk++;
    if ({bus.comp_start, bus.buf_we} !== 2'b10) $display("FAIL nom_comp_start got start=%0b we=%0b exp 1 0", bus.comp_start, bus.buf_we); else n_pass++;
    n_chk++;
    if (wa.size() != 2 || {wa[0], wp[0], wg[0]} !== {7'd0, 8'hA5, 8'h5A})
      $display("FAIL nom_word0 got n=%0d addr=%0d pix=%h wgt=%h exp 2 0 a5 5a", wa.size(), wa[0], wp[0], wg[0]);
    else n_pass++;
    n_chk++;
    if ({bus.err_short, bus.err_long} !== 2'b00) $display("FAIL nom_errs got %0b%0b exp 00", bus.err_short, bus.err_long); else n_pass++;
    done_pulse();
    n_chk++;
    if ({bus.busy, n_ok - o0, n_start - s0} !== {1'b0, 32'd1, 32'd1})
      $display("FAIL nom_done got busy=%0b frame_ok=%0d starts=%0d exp 0 1 1", bus.busy, n_ok - o0, n_start - s0);
    else n_pass++;
  endtask
  task automatic test_short();
    int s0;
    clear_log();
    s0 = n_start;
    send(16'h9600, 16'h69FF, 11, -1);
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL short_busy_at_fall got %0b exp 1", bus.busy); else n_pass++;
    step();
    n_chk++;
    if ({bus.busy, bus.err_short, bus.err_long} !== 3'b010)
      $display("FAIL short_after got busy=%0b es=%0b el=%0b exp 0 1 0", bus.busy, bus.err_short, bus.err_long);
    else n_pass++;
    repeat (4) step();
    n_chk++;
    if (wa.size() != 1 || {wa[0], wp[0], wg[0]} !== {7'd0, 8'h96, 8'h69} || n_start != s0)
      $display("FAIL short_writes got n=%0d addr=%0d pix=%h wgt=%h starts=%0d exp 1 0 96 69 0", wa.size(), wa[0], wp[0], wg[0], n_start - s0);
    else n_pass++;
  endtask
  task automatic test_long();
    int s0;
    clear_log();
    s0 = n_start;
    send(16'h0FF0, 16'hF00F, 20, -1);
    n_chk++;
    if ({bus.busy, bus.err_short, bus.err_long} !== 3'b101)
      $display("FAIL long_errs got busy=%0b es=%0b el=%0b exp 1 0 1", bus.busy, bus.err_short, bus.err_long);
    else n_pass++;
    n_chk++;
    if (wa.size() != 2 || {wa[0], wp[0], wg[0], wa[1], wp[1], wg[1]} !== {7'd0, 8'h0F, 8'hF0, 7'd1, 8'hF0, 8'h0F} || n_start != s0 + 1)
      $display("FAIL long_writes got n=%0d w0=%0d/%h/%h w1=%0d/%h/%h starts=%0d exp 2 0/0f/f0 1/f0/0f 1",
               wa.size(), wa[0], wp[0], wg[0], wa[1], wp[1], wg[1], n_start - s0);
    else n_pass++;
    bus.sync_en = 1'b1;
    repeat (2) step();
    bus.comp_done = 1'b1;
    step();
    bus.comp_done = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({bus.busy, bus.err_long} !== 2'b01 || wa.size() != 2)
      $display("FAIL long_no_restart got busy=%0b el=%0b writes=%0d exp 0 1 2", bus.busy, bus.err_long, wa.size());
    else n_pass++;
    bus.sync_en = 1'b0;
    step();
  endtask
  task automatic test_reset_mid();
    clear_log();
    send(16'hFFFF, 16'h0000, 9, -1);
    reset_n = 1'b0;
    step();
    n_chk++;
    if ({bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start, bus.busy, bus.frame_ok, bus.err_short, bus.err_long} !== '0)
      $display("FAIL mid_reset got we=%0b addr=%0d pix=%h wgt=%h start=%0b busy=%0b ok=%0b es=%0b el=%0b exp all 0",
               bus.buf_we, bus.buf_waddr, bus.pix_wdata, bus.wgt_wdata, bus.comp_start, bus.busy, bus.frame_ok, bus.err_short, bus.err_long);
    else n_pass++;
    reset_n = 1'b1;
    clear_log();
    send(16'h1234, 16'hEDCB, 16, -1);
    step();
    n_chk++;
    if (wa.size() != 2 || {wa[0], wp[0], wg[0], wa[1], wp[1], wg[1]} !== {7'd0, 8'h12, 8'hED, 7'd1, 8'h34, 8'hCB} || bus.comp_start !== 1'b1)
      $display("FAIL mid_fresh got n=%0d w0=%0d/%h/%h w1=%0d/%h/%h start=%0b exp 2 0/12/ed 1/34/cb 1",
               wa.size(), wa[0], wp[0], wg[0], wa[1], wp[1], wg[1], bus.comp_start);
    else n_pass++;
    done_pulse();
  endtask
  task automatic test_en_high_reset();
    clear_log();
    reset_n = 1'b0;
    bus.sync_en = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (4) step();
    n_chk++;
    if (bus.busy !== 1'b0 || wa.size() != 0) $display("FAIL enhigh_idle got busy=%0b writes=%0d exp 0 0", bus.busy, wa.size()); else n_pass++;
    bus.sync_en = 1'b0;
    step();
    send(16'hC3E1, 16'h3C1E, 16, -1);
    step();
    n_chk++;
    if (wa.size() != 2 || {wa[0], wp[0], wg[0], wa[1], wp[1], wg[1]} !== {7'd0, 8'hC3, 8'h3C, 7'd1, 8'hE1, 8'h1E})
      $display("FAIL enhigh_frame got n=%0d w0=%0d/%h/%h w1=%0d/%h/%h exp 2 0/c3/3c 1/e1/1e",
               wa.size(), wa[0], wp[0], wg[0], wa[1], wp[1], wg[1]);
    else n_pass++;
    done_pulse();
  endtask
  task automatic test_back_to_back();
    int o0;
    o0 = n_ok;
    send(16'hAAAA, 16'h5555, 20, -1);
    done_pulse();
    n_chk++;
    if (bus.err_long !== 1'b1 || n_ok != o0 + 1) $display("FAIL b2b_first got el=%0b frame_ok=%0d exp 1 1", bus.err_long, n_ok - o0); else n_pass++;
    clear_log();
    send(16'h8001, 16'h7FFE, 16, 4);
    n_chk++;
    if ({bus.busy, bus.err_long, bus.err_short} !== 3'b100 || n_ok != o0 + 1)
      $display("FAIL b2b_second got busy=%0b el=%0b es=%0b frame_ok=%0d exp 1 0 0 1", bus.busy, bus.err_long, bus.err_short, n_ok - o0);
    else n_pass++;
    step();
    n_chk++;
    if (wa.size() != 2 || {wa[0], wp[0], wg[0], wa[1], wp[1], wg[1]} !== {7'd0, 8'h80, 8'h7F, 7'd1, 8'h01, 8'hFE} || bus.comp_start !== 1'b1)
      $display("FAIL b2b_writes got n=%0d w0=%0d/%h/%h w1=%0d/%h/%h start=%0b exp 2 0/80/7f 1/01/fe 1",
               wa.size(), wa[0], wp[0], wg[0], wa[1], wp[1], wg[1], bus.comp_start);
    else n_pass++;
    done_pulse();
    n_chk++;
    if (n_ok != o0 + 2 || bus.busy !== 1'b0) $display("FAIL b2b_done got frame_ok=%0d busy=%0b exp 2 0", n_ok - o0, bus.busy); else n_pass++;
  endtask
  initial begin
    bus.sync_p    = 1'b0;
    bus.sync_w    = 1'b0;
    bus.sync_en   = 1'b0;
    bus.comp_done = 1'b0;
    repeat (2) step();
    test_reset();
    reset_n = 1'b1;
    step();
    test_nominal();
    test_short();
    test_long();
    test_reset_mid();
    test_en_high_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
